// File: rtl/uart_receiver.sv
// UART receive stage: oversampled start-bit validation, centre sampling of
// LSB-first data, ready/ack handshake with framing and overrun flags.
module uart_receiver #(
    parameter int WORD_SIZE  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 serial_in,
    input  logic                 rx_ack,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WORD_SIZE + 1);

    typedef enum logic [1:0] {IDLE, STARTING, RECEIVING} state_t;

    state_t               state, state_nx;
    logic [SW-1:0]        sample_count, sample_count_nx;
    logic [BW-1:0]        bit_count, bit_count_nx;
    logic [WORD_SIZE-1:0] shift_reg, shift_reg_nx;
    logic [WORD_SIZE-1:0] data_nx;
    logic                 ready_nx, framing_nx, overrun_nx;
    logic                 s1, s2;

    // Synchroniser resets to idle-high so a post-reset low is a real start edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= serial_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            sample_count <= '0;
            bit_count    <= '0;
            shift_reg    <= '0;
            data_out     <= '0;
            rx_ready     <= 1'b0;
            framing_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            sample_count <= sample_count_nx;
            bit_count    <= bit_count_nx;
            shift_reg    <= shift_reg_nx;
            data_out     <= data_nx;
            rx_ready     <= ready_nx;
            framing_err  <= framing_nx;
            overrun_err  <= overrun_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        sample_count_nx = sample_count;
        bit_count_nx    = bit_count;
        shift_reg_nx    = shift_reg;
        data_nx         = data_out;
        framing_nx      = framing_err;
        overrun_nx      = overrun_err;
        ready_nx        = (rx_ready && rx_ack) ? 1'b0 : rx_ready;

        unique case (state)
            IDLE: begin
                if (!s2) begin
                    state_nx        = STARTING;
                    sample_count_nx = '0;
                end
            end
            STARTING: begin
                if (s2) begin
                    state_nx        = IDLE;
                    sample_count_nx = '0;
                end else if (sample_count == SW'(OVERSAMPLE/2 - 1)) begin
                    state_nx        = RECEIVING;
                    sample_count_nx = '0;
                    bit_count_nx    = '0;
                end else begin
                    sample_count_nx = sample_count + 1'b1;
                end
            end
            RECEIVING: begin
                if (sample_count != SW'(OVERSAMPLE - 1)) begin
                    sample_count_nx = sample_count + 1'b1;
                end else begin
                    sample_count_nx = '0;
                    if (bit_count != BW'(WORD_SIZE)) begin
                        shift_reg_nx = {s2, shift_reg[WORD_SIZE-1:1]};
                        bit_count_nx = bit_count + 1'b1;
                    end else begin
                        // Stop-bit centre: commit overrides any ack this cycle.
                        state_nx   = IDLE;
                        data_nx    = shift_reg;
                        ready_nx   = 1'b1;
                        framing_nx = ~s2;
                        overrun_nx = rx_ready & ~rx_ack;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default parameters.
module tb_uart_receiver;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       serial_in = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] data_out;
    logic       rx_ready, framing_err, overrun_err;

    int n_chk = 0;
    int n_pass = 0;

    uart_receiver dut (
        .clock       (clock),
        .resetn      (resetn),
        .serial_in   (serial_in),
        .rx_ack      (rx_ack),
        .data_out    (data_out),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Call just after an edge (that edge is edge 0); returns just after edge 80.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            repeat (8) @(posedge clock);
            #1;
        end
        serial_in = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clock);
        #1 rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_data", data_out, 0);
        chk("rst_ready", rx_ready, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_oerr", overrun_err, 0);
        #20 resetn = 1'b1;
        idle(3);

        // Frame 0xA5: commit lands exactly on edge 79
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (78) @(posedge clock);
                #1 chk("t1_ready_e78", rx_ready, 0);
                @(posedge clock);
                #1 chk("t1_ready_e79", rx_ready, 1);
            end
        join
        chk("t1_data", data_out, 8'hA5);
        chk("t1_ferr", framing_err, 0);
        chk("t1_oerr", overrun_err, 0);
        ack_pulse();
        chk("t1_ack_ready", rx_ready, 0);

        // Two-clock glitch is rejected
        serial_in = 1'b0;
        idle(2);
        serial_in = 1'b1;
        idle(20);
        chk("t2_ready", rx_ready, 0);
        chk("t2_data", data_out, 8'hA5);
        send_frame(8'h3C, 1'b1);
        chk("t2_data2", data_out, 8'h3C);
        chk("t2_ferr", framing_err, 0);
        ack_pulse();
        idle(4);

        // Framing error still delivers the word
        send_frame(8'h3C, 1'b0);
        chk("t3_data", data_out, 8'h3C);
        chk("t3_ready", rx_ready, 1);
        chk("t3_ferr", framing_err, 1);
        ack_pulse();
        idle(10);
        send_frame(8'h81, 1'b1);
        chk("t3_data2", data_out, 8'h81);
        chk("t3_ferr2", framing_err, 0);
        chk("t3_oerr2", overrun_err, 0);
        ack_pulse();
        idle(4);

        // Back-to-back without ack -> overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("t4_data", data_out, 8'h22);
        chk("t4_oerr", overrun_err, 1);
        chk("t4_ready", rx_ready, 1);
        ack_pulse();
        chk("t4_ack_ready", rx_ready, 0);
        chk("t4_oerr_hold", overrun_err, 1);
        idle(4);

        // Ack coinciding with commit: commit wins, no overrun
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (78) @(posedge clock);
                #1 rx_ack = 1'b1;
                @(posedge clock);
                #1 rx_ack = 1'b0;
                chk("t5_ready", rx_ready, 1);
                chk("t5_oerr", overrun_err, 0);
                chk("t5_data", data_out, 8'h55);
            end
        join
        idle(4);

        // Reset during data bit 4 of 0xFF
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (44) @(posedge clock);
                #1 resetn = 1'b0;
                #2;
                chk("t6_data", data_out, 0);
                chk("t6_ready", rx_ready, 0);
                chk("t6_ferr", framing_err, 0);
                chk("t6_oerr", overrun_err, 0);
                @(posedge clock);
                #1 resetn = 1'b1;
            end
        join
        idle(10);
        chk("t6_noframe", rx_ready, 0);
        send_frame(8'h5A, 1'b1);
        chk("t6_data2", data_out, 8'h5A);
        chk("t6_ferr2", framing_err, 0);
        chk("t6_oerr2", overrun_err, 0);
        ack_pulse();
        idle(4);

        // Break: line held low commits a zero word with framing error
        serial_in = 1'b0;
        idle(85);
        chk("brk_data", data_out, 0);
        chk("brk_ready", rx_ready, 1);
        chk("brk_ferr", framing_err, 1);
        serial_in = 1'b1;
        idle(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
